// File: rtl/sensor_monitor_n_pkg.sv
// Shared types and defaults for the N-channel sensor monitor.
package sensor_monitor_n_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ALERT   = 2'd2,
        PREVENT = 2'd3
    } state_e;

    localparam int         DEBOUNCE_DEF  = 4;
    localparam logic [2:0] PREV_MASK_DEF = 3'b100;
    localparam int         CNT_W         = 8;

endpackage

// File: rtl/sensor_monitor_n_debounce.sv
// One sensor channel: debounce counter, filtered flag and event latch.
module sensor_debounce
    import sensor_monitor_n_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample,
    input  logic ack,
    output logic filt,
    output logic latched
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             latched_q, latched_d;

    always_comb begin
        cnt_d     = '0;
        filt_d    = filt_q;
        latched_d = latched_q;
        if (clr) begin
            filt_d    = 1'b0;
            latched_d = 1'b0;
        end else begin
            if (sample != filt_q) begin
                if (cnt_q == CNT_TC) begin
                    filt_d = ~filt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A rise wins over a simultaneous acknowledge.
            if (filt_d && !filt_q) begin
                latched_d = 1'b1;
            end else if (ack && !filt_q) begin
                latched_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            filt_q    <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            latched_q <= latched_d;
        end
    end

    assign filt    = filt_q;
    assign latched = latched_q;

endmodule

// File: rtl/sensor_monitor_n.sv
// N-channel sensor alarm controller; optional buzzer silence via SENSOR_MONITOR_SILENCE_EN.
// state   | meaning
// IDLE    | monitoring off, channels held clear
// MONITOR | enabled, nothing latched
// ALERT   | at least one ALERT-class channel latched
// PREVENT | only PREVENTION-class channels latched
module sensor_monitor_n
    import sensor_monitor_n_pkg::*;
#(
    parameter int              N_CH      = 3,
    parameter int              DEBOUNCE  = DEBOUNCE_DEF,
    parameter logic [N_CH-1:0] PREV_MASK = N_CH'(PREV_MASK_DEF),
    parameter int              CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            interruptor,
    input  logic [N_CH-1:0] sensor,
    input  logic            ack,
    output logic            LEDalerta,
    output logic            LEDprevencion,
    output logic            LEDnormal,
    output logic            alarma_alerta,
    output logic            alarma_prevencion,
    output logic [N_CH-1:0] latched,
    output logic [CH_W-1:0] first_ch
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   first_ch_q, first_ch_d;
    logic [N_CH-1:0]   filt_w;
    logic [N_CH-1:0]   latched_w;
    logic              clr;
    logic              buz_mute;
    logic              found_a, found_p;
    logic [CH_W-1:0]   ch_a, ch_p;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .sample  (sensor[g]),
            .ack     (ack),
            .filt    (filt_w[g]),
            .latched (latched_w[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (interruptor) state_d = MONITOR;
            end
            default: begin
                if (!interruptor)                      state_d = IDLE;
                else if (|(latched_w & ~PREV_MASK))   state_d = ALERT;
                else if (|(latched_w & PREV_MASK))    state_d = PREVENT;
                else                                  state_d = MONITOR;
            end
        endcase
    end

    // Channels only run while monitoring is established and continuing.
    assign clr = (state_q == IDLE) || (state_d == IDLE);

    always_comb begin
        found_a    = 1'b0;
        found_p    = 1'b0;
        ch_a       = '0;
        ch_p       = '0;
        first_ch_d = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (latched_w[i] && !PREV_MASK[i]) begin
                found_a = 1'b1;
                ch_a    = CH_W'(i);
            end
            if (latched_w[i] && PREV_MASK[i]) begin
                found_p = 1'b1;
                ch_p    = CH_W'(i);
            end
        end
        if (state_d != IDLE) begin
            if (found_a)      first_ch_d = ch_a;
            else if (found_p) first_ch_d = ch_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            first_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            first_ch_q <= first_ch_d;
        end
    end

`ifdef SENSOR_MONITOR_SILENCE_EN
    logic            silenced_q, silenced_d;
    logic [N_CH-1:0] lat_prev_q;

    always_comb begin
        silenced_d = silenced_q;
        if (|(latched_w & ~lat_prev_q) || !(state_d inside {ALERT, PREVENT})) begin
            silenced_d = 1'b0;
        end else if (ack && (state_q inside {ALERT, PREVENT}) && |(latched_w & filt_w)) begin
            silenced_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            silenced_q <= 1'b0;
            lat_prev_q <= '0;
        end else begin
            silenced_q <= silenced_d;
            lat_prev_q <= latched_w;
        end
    end

    assign buz_mute = silenced_q;
`else
    logic unused_filt;
    assign unused_filt = ^filt_w;
    assign buz_mute    = 1'b0;
`endif

    always_comb begin
        LEDalerta         = 1'b0;
        LEDprevencion     = 1'b0;
        LEDnormal         = 1'b0;
        alarma_alerta     = 1'b0;
        alarma_prevencion = 1'b0;
        case (state_q)
            MONITOR: LEDnormal = 1'b1;
            ALERT: begin
                LEDalerta     = 1'b1;
                alarma_alerta = !buz_mute;
            end
            PREVENT: begin
                LEDprevencion     = 1'b1;
                alarma_prevencion = !buz_mute;
            end
            default: ;
        endcase
    end

    assign latched  = latched_w;
    assign first_ch = first_ch_q;

endmodule
